pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Scoreboard-based hazard and flush controller for the in-order IF/ID/EX/LS/WB integer pipeline.
- Decides each cycle whether the decoded instruction may issue into the execute stage, or must stall on a pending GPR/CSR write.
- Converts an execute-stage branch/jump redirect into the execute-stage `inst_clear` pulse, a front-end flush window and a PC redirect.
- Sits beside the decode/execute boundary; the execute, writeback and fetch stages consume its outputs.

Parameters:
- CNT_W, 2, width of each per-register in-flight writer counter (max 2^CNT_W-1 pending writers).
- FLUSH_CYCLES, 2, number of cycles `flush_if` stays high after a redirect (legal range 1..15).
- CSR_CNT_W, 2, width of the in-flight CSR-writer counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- id_valid  in  1  decode stage holds a valid instruction
- ex_ready  in  1  execute stage can accept an instruction
- id_rs1  in  5  source register 1 index
- id_rs2  in  5  source register 2 index
- id_rs1_used  in  1  instruction reads rs1
- id_rs2_used  in  1  instruction reads rs2
- id_rd  in  5  destination register index
- id_R_wen  in  1  instruction writes a GPR
- id_csr_wen  in  1  instruction writes a CSR
- id_csr_ren  in  1  instruction reads a CSR
- ex_redirect  in  1  execute-stage branch taken / jump resolved
- ex_target  in  32  redirect target PC
- wb_valid  in  1  writeback retires an instruction this cycle
- wb_rd  in  5  retiring destination register
- wb_R_wen  in  1  retiring instruction wrote a GPR
- wb_csr_wen  in  1  retiring instruction wrote a CSR
- stall_id  out  1  hold decode; block issue
- issue  out  1  ID->EX transfer happens this cycle
- inst_clear  out  1  squash the instruction entering execute
- flush_if  out  1  discard IF/ID contents
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_pc  out  32  redirect target
- sb_busy  out  1  any GPR or CSR write in flight
- sb_err  out  1  sticky: retire seen with zero count

Behaviour:
- Reset (rst_n low at a clk edge):
  - All counters cleared; state = RUN; flush counter = 0; sb_err = 0.
  - Resulting output values: stall_id 0, issue 0, inst_clear 0, flush_if 0, redirect_valid 0, redirect_pc 0, sb_busy 0.
  - A reset mid-flush or with writers in flight discards all state; no retire bookkeeping is carried over.
- Scoreboard: cnt[1..31], each CNT_W bits. x0 is never tracked; rd == 0 or rs == 0 never causes a hazard. A separate csr_cnt of CSR_CNT_W bits tracks CSR writers.
- Hazard (combinational from registered state plus ID inputs), asserted when any of:
  - rs1 is used and cnt[rs1] != 0;
  - rs2 is used and cnt[rs2] != 0;
  - id_csr_ren or id_csr_wen, and csr_cnt != 0;
  - id_R_wen and cnt[id_rd] is at its maximum;
  - id_csr_wen and csr_cnt is at its maximum.
- stall_id = id_valid & (hazard | state == FLUSH).
- issue = id_valid & ex_ready & ~stall_id & ~inst_clear.
- On issue: cnt[id_rd]++ when id_R_wen and rd != 0; csr_cnt++ when id_csr_wen.
- On retire (wb_valid): cnt[wb_rd]-- when wb_R_wen and rd != 0; csr_cnt-- when wb_csr_wen.
- Decrement at zero: the counter stays 0 and sb_err is set (cleared only by reset).
- Same register incremented and decremented in one cycle: count unchanged; no error even if the count was 0.
- Latency: a retire in cycle N clears the hazard so issue is possible in cycle N+1; there is no same-cycle bypass.
- FSM, RUN:
  - If ex_redirect: inst_clear = 1, redirect_valid = 1, redirect_pc = ex_target, flush_if = 1 (all combinational, same cycle).
  - Next state FLUSH; flush counter loaded with FLUSH_CYCLES-1.
  - If FLUSH_CYCLES == 1, next state is RUN instead.
- FSM, FLUSH:
  - flush_if = 1 and stall_id is forced; ex_redirect is ignored (execute holds only bubbles).
  - Flush counter decrements each cycle; at 0, next state is RUN.
- redirect_pc holds its last value when redirect_valid is 0.
- Squashed instructions are never counted, so no scoreboard rollback is needed. Retires continue during FLUSH.
- sb_busy = OR of all cnt and csr_cnt being nonzero.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, three extra 32-bit outputs are present:
  - perf_stall_cyc: cycles with stall_id & ~(state == FLUSH);
  - perf_flush_cnt: number of redirects taken;
  - perf_issue_cnt: number of issues.
- Each counter is reset to 0, increments by 1 and wraps at 2^32.
- When undefined, these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Writer then dependent reader:
  - Issue rd = 5 with R_wen, then present a reader with rs1 = 5.
  - Required: stall_id = 1 until the cycle after wb_valid with wb_rd = 5; issue = 1 in that following cycle; cnt[5] ends at 0.
- Register x0: issue with rd = 0, then present a reader with rs2 = 0 → no stall; sb_busy stays 0.
- Redirect, FLUSH_CYCLES = 2:
  - ex_redirect = 1 with ex_target = 0x8000_0040 while id_valid = 1.
  - Required: inst_clear = redirect_valid = 1 for exactly 1 cycle with redirect_pc = 0x8000_0040; issue = 0 that cycle; flush_if high for 2 cycles; a second ex_redirect during FLUSH is ignored.
- Saturation, CNT_W = 2: three issues to rd = 7 with no retire, then a fourth writer to rd = 7 → stall_id = 1 until one retire of rd = 7.
- Simultaneous events: cnt[3] = 1; in one cycle issue rd = 3 and retire rd = 3 → cnt[3] stays 1; sb_err stays 0.
- Reset mid-flush: assert rst_n = 0 during FLUSH with cnt[9] = 2 → next cycle state RUN, all outputs 0, sb_busy = 0; a later retire of rd = 9 sets sb_err = 1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard hazard/flush controller for the IF/ID/EX/LS/WB pipeline.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CSR_CNT_W    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic        ex_ready,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rd,
  input  logic        id_R_wen,
  input  logic        id_csr_wen,
  input  logic        id_csr_ren,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        wb_R_wen,
  input  logic        wb_csr_wen,
  output logic        stall_id,
  output logic        issue,
  output logic        inst_clear,
  output logic        flush_if,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        sb_busy,
  output logic        sb_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_issue_cnt
`endif
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [CNT_W-1:0]     CNT_MAX = '1;
  localparam logic [CSR_CNT_W-1:0] CSR_MAX = '1;

  state_t               state, state_next;
  logic [3:0]           flush_cnt, flush_cnt_next;
  logic [31:0]          pc_q;
  logic [CNT_W-1:0]     cnt [32];
  logic [CSR_CNT_W-1:0] csr_cnt;
  logic                 hazard;
  logic [31:0]          gpr_inc, gpr_dec, gpr_zero;
  logic                 csr_inc, csr_dec, underflow;

  always_comb begin
    hazard = 1'b0;
    if (id_rs1_used && id_rs1 != 5'd0 && cnt[id_rs1] != '0) hazard = 1'b1;
    if (id_rs2_used && id_rs2 != 5'd0 && cnt[id_rs2] != '0) hazard = 1'b1;
    if ((id_csr_ren || id_csr_wen) && csr_cnt != '0) hazard = 1'b1;
    if (id_R_wen && id_rd != 5'd0 && cnt[id_rd] == CNT_MAX) hazard = 1'b1;
    if (id_csr_wen && csr_cnt == CSR_MAX) hazard = 1'b1;
  end

  assign stall_id = id_valid & (hazard | (state == FLUSH));
  assign issue    = id_valid & ex_ready & ~stall_id & ~inst_clear;

  // FLUSH lasts FLUSH_CYCLES-1 cycles so flush_if spans FLUSH_CYCLES in total
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    inst_clear     = 1'b0;
    flush_if       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = pc_q;
    case (state)
      RUN: begin
        if (ex_redirect) begin
          inst_clear     = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = ex_target;
          flush_if       = 1'b1;
          flush_cnt_next = 4'(FLUSH_CYCLES - 1);
          state_next     = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
        end
      end
      FLUSH: begin
        flush_if       = 1'b1;
        flush_cnt_next = flush_cnt - 4'd1;
        if (flush_cnt <= 4'd1) begin
          state_next     = RUN;
          flush_cnt_next = '0;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= '0;
      pc_q      <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
      if (redirect_valid) pc_q <= ex_target;
    end
  end

  always_comb begin
    gpr_inc = '0;
    gpr_dec = '0;
    if (issue && id_R_wen && id_rd != 5'd0) gpr_inc[id_rd] = 1'b1;
    if (wb_valid && wb_R_wen && wb_rd != 5'd0) gpr_dec[wb_rd] = 1'b1;
    for (int i = 0; i < 32; i++) gpr_zero[i] = (cnt[i] == '0);
    csr_inc   = issue & id_csr_wen;
    csr_dec   = wb_valid & wb_csr_wen;
    // a matching issue in the same cycle cancels a retire, so no underflow
    underflow = (|(gpr_dec & ~gpr_inc & gpr_zero)) |
                (csr_dec & ~csr_inc & (csr_cnt == '0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
      csr_cnt <= '0;
      sb_err  <= 1'b0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (gpr_inc[i] && !gpr_dec[i]) cnt[i] <= cnt[i] + 1'b1;
        else if (gpr_dec[i] && !gpr_inc[i] && !gpr_zero[i]) cnt[i] <= cnt[i] - 1'b1;
      end
      if (csr_inc && !csr_dec) csr_cnt <= csr_cnt + 1'b1;
      else if (csr_dec && !csr_inc && csr_cnt != '0) csr_cnt <= csr_cnt - 1'b1;
      if (underflow) sb_err <= 1'b1;
    end
  end

  always_comb begin
    sb_busy = (csr_cnt != '0);
    for (int i = 0; i < 32; i++) sb_busy = sb_busy | ~gpr_zero[i];
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
      perf_issue_cnt <= '0;
    end else begin
      if (stall_id && state != FLUSH) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (inst_clear) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (issue) perf_issue_cnt <= perf_issue_cnt + 32'd1;
    end
  end
`endif

endmodule
